// File: rtl/slot_dispatcher_if.sv
// Slot-table read/write port plus DMA command/completion channel of the slot dispatcher.
// cmd: cmd_valid rises with stable cmd_* fields and stays high until a cycle with cmd_ready; the beat transfers on that edge.
interface slot_dispatcher_if #(
  parameter int INDEX_WIDTH    = 2,
  parameter int SRC_ADDR_WIDTH = 32,
  parameter int SRC_SIZE_WIDTH = 26,
  parameter int DST_ADDR_WIDTH = 32,
  parameter int DST_SIZE_WIDTH = 26,
  parameter int STATUS_WIDTH   = 2,
  parameter int PROFILE_WIDTH  = 32
);
  logic [INDEX_WIDTH-1:0]    rd_index;
  logic [SRC_ADDR_WIDTH-1:0] rd_src_addr;
  logic [SRC_SIZE_WIDTH-1:0] rd_src_size;
  logic [DST_ADDR_WIDTH-1:0] rd_des_addr;
  logic [DST_SIZE_WIDTH-1:0] rd_des_size;
  logic [STATUS_WIDTH-1:0]   rd_status;
  logic [INDEX_WIDTH-1:0]    wr_index;
  logic [STATUS_WIDTH-1:0]   wr_status;
  logic                      set_status;
  logic [PROFILE_WIDTH-1:0]  wr_profile;
  logic                      set_profile;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [SRC_ADDR_WIDTH-1:0] cmd_src_addr;
  logic [SRC_SIZE_WIDTH-1:0] cmd_src_size;
  logic [DST_ADDR_WIDTH-1:0] cmd_des_addr;
  logic [DST_SIZE_WIDTH-1:0] cmd_des_size;
  logic                      cpl_valid;
  logic                      cpl_error;

  modport master (
    output rd_index,
    input  rd_src_addr, rd_src_size, rd_des_addr, rd_des_size, rd_status,
    output wr_index, wr_status, set_status, wr_profile, set_profile,
    output cmd_valid, cmd_src_addr, cmd_src_size, cmd_des_addr, cmd_des_size,
    input  cmd_ready, cpl_valid, cpl_error
  );

  modport slave (
    input  rd_index,
    output rd_src_addr, rd_src_size, rd_des_addr, rd_des_size, rd_status,
    input  wr_index, wr_status, set_status, wr_profile, set_profile,
    input  cmd_valid, cmd_src_addr, cmd_src_size, cmd_des_addr, cmd_des_size,
    output cmd_ready, cpl_valid, cpl_error
  );
endinterface

// File: rtl/slot_dispatcher.sv
// Walks the DFX slot table, issues one DMA command per PENDING slot and
// writes back status plus a completion-latency profile.
module slot_dispatcher #(
  parameter int INDEX_WIDTH    = 2,
  parameter int SRC_ADDR_WIDTH = 32,
  parameter int SRC_SIZE_WIDTH = 26,
  parameter int DST_ADDR_WIDTH = 32,
  parameter int DST_SIZE_WIDTH = 26,
  parameter int STATUS_WIDTH   = 2,
  parameter int PROFILE_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] last_index,
  output logic                   busy,
  output logic                   scan_done,
  output logic [INDEX_WIDTH:0]   err_count,
  output logic [2:0]             state_dbg,
  slot_dispatcher_if.master      tbl
);
  localparam logic [STATUS_WIDTH-1:0] ST_PENDING = STATUS_WIDTH'(1);
  localparam logic [STATUS_WIDTH-1:0] ST_DONE    = STATUS_WIDTH'(2);
  localparam logic [STATUS_WIDTH-1:0] ST_ERROR   = STATUS_WIDTH'(3);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WB, S_NEXT} state_t;

  state_t                    state_q, state_d;
  logic [INDEX_WIDTH-1:0]    cur_q, cur_d, last_q, last_d;
  logic [INDEX_WIDTH:0]      err_q, err_d;
  logic [PROFILE_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
  logic                      cmd_valid_q, cmd_valid_d;
  logic [SRC_ADDR_WIDTH-1:0] src_addr_q, src_addr_d;
  logic [SRC_SIZE_WIDTH-1:0] src_size_q, src_size_d;
  logic [DST_ADDR_WIDTH-1:0] des_addr_q, des_addr_d;
  logic [DST_SIZE_WIDTH-1:0] des_size_q, des_size_d;
  logic [STATUS_WIDTH-1:0]   wr_status_q, wr_status_d;
  logic [PROFILE_WIDTH-1:0]  wr_profile_q, wr_profile_d;
  logic                      set_q, set_d;
  logic                      done_q, done_d;

  // The latency counter sticks at all-ones instead of wrapping to a tiny profile.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + PROFILE_WIDTH'(1);

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    last_d       = last_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    cmd_valid_d  = cmd_valid_q;
    src_addr_d   = src_addr_q;
    src_size_d   = src_size_q;
    des_addr_d   = des_addr_q;
    des_size_d   = des_size_q;
    wr_status_d  = wr_status_q;
    wr_profile_d = wr_profile_q;
    set_d        = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          last_d  = last_index;
          cur_d   = '0;
          err_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (tbl.rd_status != ST_PENDING) begin
          state_d = S_NEXT;
        end else if (tbl.rd_src_size == '0) begin
          wr_status_d  = ST_ERROR;
          wr_profile_d = '0;
          set_d        = 1'b1;
          state_d      = S_WB;
        end else begin
          src_addr_d  = tbl.rd_src_addr;
          src_size_d  = tbl.rd_src_size;
          des_addr_d  = tbl.rd_des_addr;
          des_size_d  = tbl.rd_des_size;
          cmd_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (tbl.cmd_ready) begin
          cmd_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // The completion cycle itself is counted, so the earliest profile is 1.
        cnt_d = cnt_inc;
        if (tbl.cpl_valid) begin
          wr_status_d  = tbl.cpl_error ? ST_ERROR : ST_DONE;
          wr_profile_d = cnt_inc;
          set_d        = 1'b1;
          state_d      = S_WB;
        end
      end
      S_WB: begin
        if (wr_status_q == ST_ERROR) err_d = err_q + (INDEX_WIDTH+1)'(1);
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (cur_q == last_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cur_d   = cur_q + INDEX_WIDTH'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      last_q       <= '0;
      err_q        <= '0;
      cnt_q        <= '0;
      cmd_valid_q  <= 1'b0;
      src_addr_q   <= '0;
      src_size_q   <= '0;
      des_addr_q   <= '0;
      des_size_q   <= '0;
      wr_status_q  <= '0;
      wr_profile_q <= '0;
      set_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_q       <= last_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      cmd_valid_q  <= cmd_valid_d;
      src_addr_q   <= src_addr_d;
      src_size_q   <= src_size_d;
      des_addr_q   <= des_addr_d;
      des_size_q   <= des_size_d;
      wr_status_q  <= wr_status_d;
      wr_profile_q <= wr_profile_d;
      set_q        <= set_d;
      done_q       <= done_d;
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign scan_done        = done_q;
  assign err_count        = err_q;
  assign state_dbg        = state_q;
  assign tbl.rd_index     = cur_q;
  assign tbl.wr_index     = cur_q;
  assign tbl.wr_status    = wr_status_q;
  assign tbl.wr_profile   = wr_profile_q;
  assign tbl.set_status   = set_q;
  assign tbl.set_profile  = set_q;
  assign tbl.cmd_valid    = cmd_valid_q;
  assign tbl.cmd_src_addr = src_addr_q;
  assign tbl.cmd_src_size = src_size_q;
  assign tbl.cmd_des_addr = des_addr_q;
  assign tbl.cmd_des_size = des_size_q;
endmodule
